exmem_skid_stage: RTL and testbench

Parametrised successor to the EX/MEM pipeline register: carries the execute-stage result, store data, destination register and a control vector (WB, load) into the memory stage. Unlike a plain always-load register, it has a valid/ready handshake on both sides. It uses a 2-entry skid buffer so that `in_ready` never depends combinationally on `out_ready`. It also supports a flush that inserts a bubble and a saturating back-pressure counter for performance monitoring.

---
 rtl/exmem_skid_stage.sv | 169 ++++++++++++++++
 tb/tb_exmem_skid_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage with valid/ready handshakes on both sides.
// A two-entry skid buffer (main + skid) keeps in_ready a function of
// registered state only, so there is no out_ready -> in_ready path.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | main invalid, skid invalid; outputs idle, ctrl reads 0
// ONE   | main valid, skid invalid; main drives outputs, can accept
// FULL  | main and skid valid; in_ready low until main drains
module exmem_skid_stage #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int CTRL_W  = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [DATA_W-1:0]  in_resM,
    input  logic [RD_W-1:0]    in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_resM,
    output logic [RD_W-1:0]    out_rd,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic main_valid, skid_valid;
    logic accept, drain;
    logic load_main_in, load_main_skid, load_skid_in;
    logic clr_main_ctrl, clr_skid_ctrl;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_result, skid_result;
    logic [DATA_W-1:0] main_resM, skid_resM;
    logic [RD_W-1:0]   main_rd, skid_rd;

    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_FULL);

    // Reset forces in_ready low in the same cycle so nothing is accepted then.
    assign in_ready = !skid_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    // Next state and register-load selects; flush overrides any transfer.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        clr_main_ctrl  = 1'b0;
        clr_skid_ctrl  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt    = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (drain) begin
                    state_nxt     = ST_EMPTY;
                    clr_main_ctrl = 1'b1;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_nxt      = ST_ONE;
                    load_main_skid = 1'b1;
                    clr_skid_ctrl  = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_EMPTY;
                clr_main_ctrl = 1'b1;
                clr_skid_ctrl = 1'b1;
            end
        endcase
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
            clr_main_ctrl  = 1'b1;
            clr_skid_ctrl  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Main entry: loads from input or promoted skid; ctrl cleared when it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl   <= '0;
            main_result <= '0;
            main_resM   <= '0;
            main_rd     <= '0;
        end else if (load_main_in) begin
            main_ctrl   <= in_ctrl;
            main_result <= in_result;
            main_resM   <= in_resM;
            main_rd     <= in_rd;
        end else if (load_main_skid) begin
            main_ctrl   <= skid_ctrl;
            main_result <= skid_result;
            main_resM   <= skid_resM;
            main_rd     <= skid_rd;
        end else if (clr_main_ctrl) begin
            main_ctrl   <= '0;
        end
    end

    // Skid entry: catches the one entry accepted while main is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_ctrl   <= '0;
            skid_result <= '0;
            skid_resM   <= '0;
            skid_rd     <= '0;
        end else if (load_skid_in) begin
            skid_ctrl   <= in_ctrl;
            skid_result <= in_result;
            skid_resM   <= in_resM;
            skid_rd     <= in_rd;
        end else if (clr_skid_ctrl) begin
            skid_ctrl   <= '0;
        end
    end

    // Saturating back-pressure counter; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign out_valid  = main_valid;
    assign out_ctrl   = main_ctrl;
    assign out_result = main_result;
    assign out_resM   = main_resM;
    assign out_rd     = main_rd;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage (STALL_W=3 so saturation is reachable).
// Each vector drives inputs for one cycle; expected values describe what the
// outputs show just before that cycle's rising edge.
module tb_exmem_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_result;
    logic [31:0] in_resM;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [31:0] out_result;
    logic [31:0] out_resM;
    logic [4:0]  out_rd;
    logic [2:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    exmem_skid_stage #(
        .DATA_W(32), .RD_W(5), .CTRL_W(2), .STALL_W(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_result(in_result), .in_resM(in_resM), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_result(out_result), .out_resM(out_resM), .out_rd(out_rd),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rst, fl, iv, ic, ires, irm, ird, ordy;
        logic [31:0] e_ir, e_ov, e_oc, e_res, e_rm, e_rd, e_st, cd;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [1:0] ic,
                         input logic [31:0] ires, input logic [31:0] irm,
                         input logic [4:0] ird, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_ctrl = ic;
        in_result = ires; in_resM = irm; in_rd = ird; out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        drive(v.rst[0], v.fl[0], v.iv[0], v.ic[1:0], v.ires, v.irm, v.ird[4:0], v.ordy[0]);
        @(negedge clk);
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), v.e_ir);
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), v.e_ov);
        chk($sformatf("v%0d out_ctrl", idx), 32'(out_ctrl), v.e_oc);
        chk($sformatf("v%0d stall_cnt", idx), 32'(stall_cnt), v.e_st);
        if (v.cd[0]) begin
            chk($sformatf("v%0d out_result", idx), out_result, v.e_res);
            chk($sformatf("v%0d out_resM", idx), out_resM, v.e_rm);
            chk($sformatf("v%0d out_rd", idx), 32'(out_rd), v.e_rd);
        end
        tick();
    endtask

    initial begin
        //            rst fl iv ic ires    irm      ird ordy  e_ir ov oc e_res  e_rm    e_rd st cd
        // reset held (second cycle) with in_valid high, then release
        vecs[0]  = '{1, 0, 1, 3, 'h99,  'h990, 9,  0,   0, 0, 0, 0,    0,      0,  0, 1};
        vecs[1]  = '{0, 0, 0, 0, 0,     0,     0,  1,   1, 0, 0, 0,    0,      0,  0, 1};
        // streaming with out_ready high
        vecs[2]  = '{0, 0, 1, 1, 'h10,  'h100, 1,  1,   1, 0, 0, 0,    0,      0,  0, 0};
        vecs[3]  = '{0, 0, 1, 1, 'h20,  'h200, 2,  1,   1, 1, 1, 'h10, 'h100,  1,  0, 1};
        vecs[4]  = '{0, 0, 1, 1, 'h30,  'h300, 3,  1,   1, 1, 1, 'h20, 'h200,  2,  0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0,     0,     0,  1,   1, 1, 1, 'h30, 'h300,  3,  0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0,     0,     0,  0,   1, 0, 0, 0,    0,      0,  0, 0};
        // back-pressure: A, B fill the stage, C waits upstream
        vecs[7]  = '{0, 0, 1, 2, 'hA,   'hA0,  10, 0,   1, 0, 0, 0,    0,      0,  0, 0};
        vecs[8]  = '{0, 0, 1, 2, 'hB,   'hB0,  11, 0,   1, 1, 2, 'hA,  'hA0,   10, 0, 1};
        vecs[9]  = '{0, 0, 1, 2, 'hC,   'hC0,  12, 0,   0, 1, 2, 'hA,  'hA0,   10, 1, 1};
        vecs[10] = '{0, 0, 1, 2, 'hC,   'hC0,  12, 0,   0, 1, 2, 'hA,  'hA0,   10, 2, 1};
        vecs[11] = '{0, 0, 1, 2, 'hC,   'hC0,  12, 1,   0, 1, 2, 'hA,  'hA0,   10, 3, 1};
        vecs[12] = '{0, 0, 1, 2, 'hC,   'hC0,  12, 1,   1, 1, 2, 'hB,  'hB0,   11, 3, 1};
        vecs[13] = '{0, 0, 0, 0, 0,     0,     0,  1,   1, 1, 2, 'hC,  'hC0,   12, 3, 1};
        vecs[14] = '{0, 0, 0, 0, 0,     0,     0,  1,   1, 0, 0, 0,    0,      0,  3, 0};
        // flush while FULL with ctrl=11, incoming 0x55 and out_ready high
        vecs[15] = '{0, 0, 1, 3, 'h1,   'h11,  4,  0,   1, 0, 0, 0,    0,      0,  3, 0};
        vecs[16] = '{0, 0, 1, 3, 'h2,   'h22,  5,  0,   1, 1, 3, 'h1,  'h11,   4,  3, 1};
        vecs[17] = '{0, 1, 1, 3, 'h55,  'h55,  7,  1,   0, 1, 3, 'h1,  'h11,   4,  4, 1};
        vecs[18] = '{0, 0, 0, 0, 0,     0,     0,  1,   1, 0, 0, 0,    0,      0,  4, 0};
        // flush while ONE discards a same-cycle accept and drain
        vecs[19] = '{0, 0, 1, 1, 'h66,  'h660, 6,  0,   1, 0, 0, 0,    0,      0,  4, 0};
        vecs[20] = '{0, 1, 1, 1, 'h77,  'h770, 7,  1,   1, 1, 1, 'h66, 'h660,  6,  4, 1};
        vecs[21] = '{0, 0, 0, 0, 0,     0,     0,  0,   1, 0, 0, 0,    0,      0,  4, 0};

        drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h99, 32'h990, 5'd9, 1'b0);
        tick();

        for (int i = 0; i < 22; i++) begin
            run_vec(i, vecs[i]);
            if (out_valid && out_result == 32'h55) begin
                n_cmp++;
                n_bad++;
                $display("FAIL v%0d flushed_entry: got 0x%0h expected not 0x55", i, out_result);
            end
        end

        // Saturation: one entry held with out_ready low for 10 cycles.
        drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h5A, 32'h5A0, 5'd3, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("sat%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("sat%0d out_result", k), out_result, 32'h5A);
            chk($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), (4 + k > 7) ? 32'd7 : 32'(4 + k));
            tick();
        end
        // Flush keeps the saturated count.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_flush out_valid", 32'(out_valid), 32'd0);
        chk("post_flush out_ctrl", 32'(out_ctrl), 32'd0);
        chk("post_flush stall_cnt", 32'(stall_cnt), 32'd7);
        tick();
        // Reset clears the counter; in_ready low while rst is high.
        drive(1'b1, 1'b0, 1'b1, 2'b01, 32'h1, 32'h1, 5'd1, 1'b0);
        @(negedge clk);
        chk("rst_high in_ready", 32'(in_ready), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        chk("post_rst stall_cnt", 32'(stall_cnt), 32'd0);
        chk("post_rst out_valid", 32'(out_valid), 32'd0);
        chk("post_rst in_ready", 32'(in_ready), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
